// File: rtl/xgmii_tx_framer.sv
// XGMII transmit framer: wraps 64-bit user words in start/terminate columns with a minimum idle gap,
// aborting with an error column on source underrun or link loss since XGMII cannot stall.
module xgmii_tx_framer #(
    parameter int unsigned IPG_WORDS     = 1,
    parameter logic [31:0] FRAME_CNT_RST = 32'd0,
    parameter logic [15:0] ABORT_CNT_RST = 16'd0
) (
    input  logic        usrclk,
    input  logic        reset,
    input  logic        link_up,
    input  logic [63:0] din,
    input  logic        din_valid,
    input  logic        din_last,
    output logic        din_ready,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic        tx_busy,
    output logic        abort,
    output logic [31:0] frame_count,
    output logic [15:0] abort_count
);
    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] START_W = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
    localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_TERM = 3'd2;
    localparam logic [2:0] S_IPG  = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;

    localparam logic [3:0] IPG_LAST = 4'(IPG_WORDS - 1);

    logic [2:0]  state_q, state_d;
    logic [63:0] txd_q, txd_d;
    logic [7:0]  txc_q, txc_d;
    logic        abort_q, abort_d;
    logic [3:0]  ipg_cnt_q, ipg_cnt_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] abort_cnt_q, abort_cnt_d;

    // Each state computes the word that goes on the wire next cycle, so START_W is
    // registered out while the state is already DATA and ready for the first word.
    always_comb begin
        state_d     = state_q;
        txd_d       = IDLE_W;
        txc_d       = 8'hFF;
        abort_d     = 1'b0;
        ipg_cnt_d   = ipg_cnt_q;
        frame_cnt_d = frame_cnt_q;
        abort_cnt_d = abort_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (din_valid && link_up) begin
                    txd_d   = START_W;
                    txc_d   = 8'h01;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (!link_up || !din_valid) begin
                    txd_d   = ERR_W;
                    abort_d = 1'b1;
                    state_d = S_DROP;
                end else begin
                    txd_d = din;
                    txc_d = 8'h00;
                    if (din_last) state_d = S_TERM;
                end
            end
            S_TERM: begin
                txd_d       = TERM_W;
                frame_cnt_d = frame_cnt_q + 32'd1;
                ipg_cnt_d   = 4'd0;
                state_d     = S_IPG;
            end
            S_IPG: begin
                if (ipg_cnt_q == IPG_LAST) state_d = S_IDLE;
                else                       ipg_cnt_d = ipg_cnt_q + 4'd1;
            end
            S_DROP: begin
                if (din_valid && din_last) begin
                    ipg_cnt_d = 4'd0;
                    state_d   = S_IPG;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_d && (abort_cnt_q != 16'hFFFF)) abort_cnt_d = abort_cnt_q + 16'd1;
    end

    always_ff @(posedge usrclk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            txd_q       <= IDLE_W;
            txc_q       <= 8'hFF;
            abort_q     <= 1'b0;
            ipg_cnt_q   <= 4'd0;
            frame_cnt_q <= FRAME_CNT_RST;
            abort_cnt_q <= ABORT_CNT_RST;
        end else begin
            state_q     <= state_d;
            txd_q       <= txd_d;
            txc_q       <= txc_d;
            abort_q     <= abort_d;
            ipg_cnt_q   <= ipg_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    // A word offered while the link is down in DATA is left for the drain state to take.
    assign din_ready   = (state_q == S_DROP) || ((state_q == S_DATA) && link_up);
    assign tx_busy     = (state_q != S_IDLE);
    assign xgmii_txd   = txd_q;
    assign xgmii_txc   = txc_q;
    assign abort       = abort_q;
    assign frame_count = frame_cnt_q;
    assign abort_count = abort_cnt_q;
endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Bench for xgmii_tx_framer: three instances (IPG 1, IPG 4, preloaded counters) share one stimulus;
// each scenario pushes expected wire words per cycle and pops them against the selected instance.
module tb_xgmii_tx_framer;
    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] START_W = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
    localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] D1 = 64'h1111111111111111;
    localparam logic [63:0] D2 = 64'h2222222222222222;
    localparam logic [63:0] D3 = 64'h3333333333333333;
    localparam logic [63:0] D4 = 64'h4444444444444444;
    localparam logic [63:0] D5 = 64'h5555555555555555;
    localparam logic [63:0] DA = 64'hA5A5A5A5_0BADCAFE;

    typedef struct packed {
        logic lnk; logic vld; logic lst; logic [63:0] d;
        logic [63:0] txd; logic [7:0] txc; logic ab; logic rdy;
    } step_t;
    typedef struct packed {
        logic [63:0] txd; logic [7:0] txc; logic ab; logic rdy;
    } obs_t;

    logic        usrclk = 1'b0;
    logic        reset = 1'b1;
    logic        link_up = 1'b0;
    logic        din_valid = 1'b0;
    logic        din_last = 1'b0;
    logic [63:0] din = 64'd0;

    logic        a_rdy, a_busy, a_ab, b_rdy, b_busy, b_ab, c_rdy, c_busy, c_ab;
    logic [63:0] a_txd, b_txd, c_txd;
    logic [7:0]  a_txc, b_txc, c_txc;
    logic [31:0] a_fc, b_fc, c_fc;
    logic [15:0] a_ac, b_ac, c_ac;

    int   total = 0;
    int   bad = 0;
    int   sel = 0;
    obs_t obs;
    obs_t sb[$];
    logic [31:0] cur_fc;
    logic [15:0] cur_ac;
    logic        cur_busy;

    always #5 usrclk = ~usrclk;

    xgmii_tx_framer #(.IPG_WORDS(1)) u_a (
        .usrclk(usrclk), .reset(reset), .link_up(link_up), .din(din), .din_valid(din_valid),
        .din_last(din_last), .din_ready(a_rdy), .xgmii_txd(a_txd), .xgmii_txc(a_txc),
        .tx_busy(a_busy), .abort(a_ab), .frame_count(a_fc), .abort_count(a_ac));

    xgmii_tx_framer #(.IPG_WORDS(4)) u_b (
        .usrclk(usrclk), .reset(reset), .link_up(link_up), .din(din), .din_valid(din_valid),
        .din_last(din_last), .din_ready(b_rdy), .xgmii_txd(b_txd), .xgmii_txc(b_txc),
        .tx_busy(b_busy), .abort(b_ab), .frame_count(b_fc), .abort_count(b_ac));

    xgmii_tx_framer #(.IPG_WORDS(1), .FRAME_CNT_RST(32'hFFFFFFFF), .ABORT_CNT_RST(16'hFFFE)) u_c (
        .usrclk(usrclk), .reset(reset), .link_up(link_up), .din(din), .din_valid(din_valid),
        .din_last(din_last), .din_ready(c_rdy), .xgmii_txd(c_txd), .xgmii_txc(c_txc),
        .tx_busy(c_busy), .abort(c_ab), .frame_count(c_fc), .abort_count(c_ac));

    function automatic step_t st(input logic lnk, input logic vld, input logic lst, input logic [63:0] d,
                                 input logic [63:0] txd, input logic [7:0] txc, input logic ab, input logic rdy);
        st = {lnk, vld, lst, d, txd, txc, ab, rdy};
    endfunction

    task automatic tick();
        @(posedge usrclk);
        #1;
        case (sel)
            0:       begin obs = {a_txd, a_txc, a_ab, a_rdy}; cur_fc = a_fc; cur_ac = a_ac; cur_busy = a_busy; end
            1:       begin obs = {b_txd, b_txc, b_ab, b_rdy}; cur_fc = b_fc; cur_ac = b_ac; cur_busy = b_busy; end
            default: begin obs = {c_txd, c_txc, c_ab, c_rdy}; cur_fc = c_fc; cur_ac = c_ac; cur_busy = c_busy; end
        endcase
    endtask

    task automatic run_cycle(input step_t s);
        link_up   = s.lnk;
        din_valid = s.vld;
        din_last  = s.lst;
        din       = s.d;
        sb.push_back({s.txd, s.txc, s.ab, s.rdy});
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; din_valid = 1'b0; din_last = 1'b0; link_up = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0;
        tick();
        total += 7;
        if (a_txd !== IDLE_W) begin bad++; $display("FAIL reset_txd: got %h want %h", a_txd, IDLE_W); end
        if (a_txc !== 8'hFF)  begin bad++; $display("FAIL reset_txc: got %h want ff", a_txc); end
        if (a_rdy !== 1'b0)   begin bad++; $display("FAIL reset_rdy: got %b want 0", a_rdy); end
        if (a_busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        if (a_ab !== 1'b0)    begin bad++; $display("FAIL reset_abort: got %b want 0", a_ab); end
        if (a_fc !== 32'd0)   begin bad++; $display("FAIL reset_fc: got %h want 0", a_fc); end
        if (a_ac !== 16'd0)   begin bad++; $display("FAIL reset_ac: got %h want 0", a_ac); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        step_t q[$];
        obs_t  e;
        do_reset();
        sel = 0;
        q.push_back(st(1, 1, 0, D1, START_W, 8'h01, 0, 1));
        q.push_back(st(1, 1, 0, D1, D1, 8'h00, 0, 1));
        q.push_back(st(1, 1, 0, D2, D2, 8'h00, 0, 1));
        q.push_back(st(1, 1, 1, D3, D3, 8'h00, 0, 0));
        q.push_back(st(1, 1, 0, DA, TERM_W, 8'hFF, 0, 0));
        q.push_back(st(1, 1, 0, DA, IDLE_W, 8'hFF, 0, 0));
        q.push_back(st(1, 1, 1, DA, START_W, 8'h01, 0, 1));
        q.push_back(st(1, 1, 1, DA, DA, 8'h00, 0, 0));
        q.push_back(st(1, 0, 0, 64'd0, TERM_W, 8'hFF, 0, 0));
        q.push_back(st(1, 0, 0, 64'd0, IDLE_W, 8'hFF, 0, 0));
        q.push_back(st(1, 0, 0, 64'd0, IDLE_W, 8'hFF, 0, 0));
        foreach (q[i]) begin
            run_cycle(q[i]);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL basic[%0d]: got txd=%h txc=%h ab=%b rdy=%b want txd=%h txc=%h ab=%b rdy=%b",
                         i, obs.txd, obs.txc, obs.ab, obs.rdy, e.txd, e.txc, e.ab, e.rdy);
            end
            if (i == 4) begin
                total++;
                if (cur_fc !== 32'd1) begin bad++; $display("FAIL basic_fc1: got %0d want 1", cur_fc); end
            end
        end
        total++;
        if (cur_fc !== 32'd2) begin bad++; $display("FAIL basic_fc2: got %0d want 2", cur_fc); end
    endtask

    task automatic test_ipg4();
        step_t q[$];
        obs_t  e;
        logic [63:0] d;
        do_reset();
        sel = 1;
        for (int f = 0; f < 2; f++) begin
            d = 64'hC0DE000000000000 | 64'(f);
            q.push_back(st(1, 1, 1, d, START_W, 8'h01, 0, 1));
            q.push_back(st(1, 1, 1, d, d, 8'h00, 0, 0));
            q.push_back(st(1, 1, 1, d, TERM_W, 8'hFF, 0, 0));
            for (int k = 0; k < 4; k++) q.push_back(st(1, 1, 1, d, IDLE_W, 8'hFF, 0, 0));
        end
        q.push_back(st(1, 1, 1, DA, START_W, 8'h01, 0, 1));
        q.push_back(st(1, 1, 1, DA, DA, 8'h00, 0, 0));
        q.push_back(st(1, 0, 0, 64'd0, TERM_W, 8'hFF, 0, 0));
        foreach (q[i]) begin
            run_cycle(q[i]);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL ipg4[%0d]: got txd=%h txc=%h ab=%b rdy=%b want txd=%h txc=%h ab=%b rdy=%b",
                         i, obs.txd, obs.txc, obs.ab, obs.rdy, e.txd, e.txc, e.ab, e.rdy);
            end
        end
        total++;
        if (cur_fc !== 32'd3) begin bad++; $display("FAIL ipg4_fc: got %0d want 3", cur_fc); end
    endtask

    task automatic test_underrun();
        step_t q[$];
        obs_t  e;
        do_reset();
        sel = 0;
        q.push_back(st(1, 1, 0, D1, START_W, 8'h01, 0, 1));
        q.push_back(st(1, 1, 0, D1, D1, 8'h00, 0, 1));
        q.push_back(st(1, 1, 0, D2, D2, 8'h00, 0, 1));
        q.push_back(st(1, 0, 0, 64'd0, ERR_W, 8'hFF, 1, 1));
        q.push_back(st(1, 1, 0, D3, IDLE_W, 8'hFF, 0, 1));
        q.push_back(st(1, 1, 0, D4, IDLE_W, 8'hFF, 0, 1));
        q.push_back(st(1, 1, 1, D5, IDLE_W, 8'hFF, 0, 0));
        q.push_back(st(1, 0, 0, 64'd0, IDLE_W, 8'hFF, 0, 0));
        q.push_back(st(1, 0, 0, 64'd0, IDLE_W, 8'hFF, 0, 0));
        foreach (q[i]) begin
            run_cycle(q[i]);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL underrun[%0d]: got txd=%h txc=%h ab=%b rdy=%b want txd=%h txc=%h ab=%b rdy=%b",
                         i, obs.txd, obs.txc, obs.ab, obs.rdy, e.txd, e.txc, e.ab, e.rdy);
            end
        end
        total += 2;
        if (cur_fc !== 32'd0) begin bad++; $display("FAIL underrun_fc: got %0d want 0", cur_fc); end
        if (cur_ac !== 16'd1) begin bad++; $display("FAIL underrun_ac: got %0d want 1", cur_ac); end
    endtask

    task automatic test_link_drop();
        step_t q[$];
        obs_t  e;
        do_reset();
        sel = 0;
        q.push_back(st(1, 1, 0, D1, START_W, 8'h01, 0, 1));
        q.push_back(st(1, 1, 0, D1, D1, 8'h00, 0, 1));
        q.push_back(st(0, 1, 0, D2, ERR_W, 8'hFF, 1, 1));
        q.push_back(st(0, 1, 0, D2, IDLE_W, 8'hFF, 0, 1));
        q.push_back(st(0, 1, 1, D3, IDLE_W, 8'hFF, 0, 0));
        for (int k = 0; k < 4; k++) q.push_back(st(0, 1, 0, D4, IDLE_W, 8'hFF, 0, 0));
        foreach (q[i]) begin
            run_cycle(q[i]);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL link_drop[%0d]: got txd=%h txc=%h ab=%b rdy=%b want txd=%h txc=%h ab=%b rdy=%b",
                         i, obs.txd, obs.txc, obs.ab, obs.rdy, e.txd, e.txc, e.ab, e.rdy);
            end
        end
        total += 3;
        if (cur_ac !== 16'd1) begin bad++; $display("FAIL link_drop_ac: got %0d want 1", cur_ac); end
        if (cur_fc !== 32'd0) begin bad++; $display("FAIL link_drop_fc: got %0d want 0", cur_fc); end
        if (cur_busy !== 1'b0) begin bad++; $display("FAIL link_drop_busy: got %b want 0", cur_busy); end
    endtask

    task automatic test_reset_mid();
        step_t q[$];
        obs_t  e;
        do_reset();
        sel = 0;
        q.push_back(st(1, 1, 1, D1, START_W, 8'h01, 0, 1));
        q.push_back(st(1, 1, 1, D1, D1, 8'h00, 0, 0));
        q.push_back(st(1, 0, 0, 64'd0, TERM_W, 8'hFF, 0, 0));
        q.push_back(st(1, 1, 0, D2, IDLE_W, 8'hFF, 0, 0));
        q.push_back(st(1, 1, 0, D2, START_W, 8'h01, 0, 1));
        q.push_back(st(1, 1, 0, D2, D2, 8'h00, 0, 1));
        foreach (q[i]) begin
            run_cycle(q[i]);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_mid_pre[%0d]: got txd=%h txc=%h ab=%b rdy=%b want txd=%h txc=%h ab=%b rdy=%b",
                         i, obs.txd, obs.txc, obs.ab, obs.rdy, e.txd, e.txc, e.ab, e.rdy);
            end
        end
        total++;
        if (cur_fc !== 32'd1) begin bad++; $display("FAIL reset_mid_fc_pre: got %0d want 1", cur_fc); end
        reset = 1'b1;
        #2;
        total += 5;
        if (a_txd !== IDLE_W) begin bad++; $display("FAIL reset_mid_txd: got %h want %h", a_txd, IDLE_W); end
        if (a_txc !== 8'hFF)  begin bad++; $display("FAIL reset_mid_txc: got %h want ff", a_txc); end
        if (a_fc !== 32'd0)   begin bad++; $display("FAIL reset_mid_fc: got %0d want 0", a_fc); end
        if (a_busy !== 1'b0)  begin bad++; $display("FAIL reset_mid_busy: got %b want 0", a_busy); end
        if (a_rdy !== 1'b0)   begin bad++; $display("FAIL reset_mid_rdy: got %b want 0", a_rdy); end
        tick();
        reset = 1'b0;
        q.delete();
        q.push_back(st(1, 1, 1, D3, START_W, 8'h01, 0, 1));
        q.push_back(st(1, 1, 1, D3, D3, 8'h00, 0, 0));
        q.push_back(st(1, 0, 0, 64'd0, TERM_W, 8'hFF, 0, 0));
        q.push_back(st(1, 0, 0, 64'd0, IDLE_W, 8'hFF, 0, 0));
        foreach (q[i]) begin
            run_cycle(q[i]);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_mid_post[%0d]: got txd=%h txc=%h ab=%b rdy=%b want txd=%h txc=%h ab=%b rdy=%b",
                         i, obs.txd, obs.txc, obs.ab, obs.rdy, e.txd, e.txc, e.ab, e.rdy);
            end
        end
    endtask

    task automatic test_saturation();
        step_t q[$];
        obs_t  e;
        do_reset();
        sel = 2;
        for (int k = 0; k < 2; k++) begin
            q.push_back(st(1, 1, 0, D1, START_W, 8'h01, 0, 1));
            q.push_back(st(1, 0, 0, 64'd0, ERR_W, 8'hFF, 1, 1));
            q.push_back(st(1, 1, 1, D1, IDLE_W, 8'hFF, 0, 0));
            q.push_back(st(1, 0, 0, 64'd0, IDLE_W, 8'hFF, 0, 0));
        end
        q.push_back(st(1, 1, 1, D2, START_W, 8'h01, 0, 1));
        q.push_back(st(1, 1, 1, D2, D2, 8'h00, 0, 0));
        q.push_back(st(1, 0, 0, 64'd0, TERM_W, 8'hFF, 0, 0));
        q.push_back(st(1, 0, 0, 64'd0, IDLE_W, 8'hFF, 0, 0));
        foreach (q[i]) begin
            run_cycle(q[i]);
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL sat[%0d]: got txd=%h txc=%h ab=%b rdy=%b want txd=%h txc=%h ab=%b rdy=%b",
                         i, obs.txd, obs.txc, obs.ab, obs.rdy, e.txd, e.txc, e.ab, e.rdy);
            end
            if (q[i].ab) begin
                total++;
                if (cur_ac !== 16'hFFFF) begin bad++; $display("FAIL sat_ac[%0d]: got %h want ffff", i, cur_ac); end
            end
            if (q[i].txd == TERM_W) begin
                total++;
                if (cur_fc !== 32'd0) begin bad++; $display("FAIL sat_fc_wrap: got %h want 0", cur_fc); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ipg4();
        test_underrun();
        test_link_drop();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
